// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared state encoding, pattern entry layout and note-length lookup
package note_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    localparam int END_BIT  = 7;
    localparam int MODE_HI  = 6;
    localparam int MODE_LO  = 5;
    localparam int REST_BIT = 4;
    localparam int NOTE_HI  = 3;

    localparam logic [1:0] MODE_WHOLE   = 2'b00;
    localparam logic [1:0] MODE_HALF    = 2'b01;
    localparam logic [1:0] MODE_QUARTER = 2'b10;
    localparam logic [1:0] MODE_EIGHTH  = 2'b11;

    // Note length expressed in eighth-note ticks.
    function automatic logic [3:0] mode_ticks(input logic [1:0] mode);
        case (mode)
            MODE_WHOLE:   return 4'd8;
            MODE_HALF:    return 4'd4;
            MODE_QUARTER: return 4'd2;
            default:      return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/tempo_tick.sv
// rtl/tempo_tick.sv - BPM-driven eighth-note tick from a phase accumulator
module tempo_tick #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLR,
    input  logic       RUN,
    input  logic [7:0] BPM,
    output logic       TICK
);

    localparam longint unsigned LIMIT_W = longint'(CLK_HZ) * 60;
    localparam logic [31:0]     LIMIT   = LIMIT_W[31:0];

    logic [31:0] acc_q, acc_d;
    logic [31:0] inc;
    logic [31:0] headroom;
    logic        wrap;

    // Comparing against the remaining headroom keeps every sum below LIMIT,
    // so the accumulator never needs a carry bit.
    assign inc      = {23'd0, BPM, 1'b0};
    assign headroom = LIMIT - acc_q;
    assign wrap     = (inc >= headroom);
    assign TICK     = RUN && wrap;

    always_comb begin
        acc_d = acc_q;
        if (CLR) begin
            acc_d = 32'd0;
        end else if (RUN) begin
            acc_d = wrap ? (inc - headroom) : (acc_q + inc);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= 32'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - steps a pattern memory and gates audio_controller per note
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int          ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic              LOOP,
    input  logic [7:0]        BPM,
    output logic [ADDR_W-1:0] PAT_ADDR,
    input  logic [7:0]        PAT_DATA,
    output logic [3:0]        NOTE,
    output logic [1:0]        MODE,
    output logic [7:0]        BPM_OUT,
    output logic              NOTE_EN,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        dur_q, dur_d;
    logic [3:0]        note_q, note_d;
    logic [1:0]        mode_q, mode_d;
    logic [7:0]        bpm_q, bpm_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              clr, tick, start_ok, at_end;

    assign start_ok = (state_q == S_IDLE) && START && !STOP && (BPM != 8'd0);

    tempo_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (clr),
        .RUN  (state_q == S_PLAY),
        .BPM  (bpm_q),
        .TICK (tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dur_d   = dur_q;
        note_d  = note_q;
        mode_d  = mode_q;
        bpm_d   = bpm_q;
        en_d    = en_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        at_end  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_FETCH;
                    bpm_d   = BPM;
                    addr_d  = '0;
                    clr     = 1'b1;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (PAT_DATA[END_BIT]) begin
                    at_end = 1'b1;
                end else begin
                    note_d  = PAT_DATA[NOTE_HI:0];
                    mode_d  = PAT_DATA[MODE_HI:MODE_LO];
                    dur_d   = mode_ticks(PAT_DATA[MODE_HI:MODE_LO]);
                    en_d    = !PAT_DATA[REST_BIT];
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    dur_d = dur_q - 4'd1;
                    if (dur_q == 4'd1) begin
                        en_d = 1'b0;
                        if (addr_q == ADDR_MAX) begin
                            at_end = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_ONE;
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An END at address 0 always finishes, so LOOP can never spin on an empty pattern.
        if (at_end) begin
            if (LOOP && (addr_q != '0)) begin
                addr_d  = '0;
                state_d = S_FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (STOP && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            note_d  = note_q;
            mode_d  = mode_q;
            en_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dur_q   <= 4'd0;
            note_q  <= 4'd0;
            mode_q  <= 2'd0;
            bpm_q   <= 8'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dur_q   <= dur_d;
            note_q  <= note_d;
            mode_q  <= mode_d;
            bpm_q   <= bpm_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign PAT_ADDR = addr_q;
    assign NOTE     = note_q;
    assign MODE     = mode_q;
    assign BPM_OUT  = bpm_q;
    assign NOTE_EN  = en_q;
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer against a timeline model
module tb_note_sequencer;

    localparam int     CLK_HZ = 100;
    localparam longint LIMIT  = 6000;

    typedef logic [21:0] obs_t; // busy, done, en, note[4], mode[2], addr[5], bpm[8]

    logic       clk = 1'b0;
    logic       rst, start, stop, loop_en;
    logic [7:0] bpm;
    logic [4:0] pat_addr;
    logic [7:0] pat_data;
    logic [3:0] note;
    logic [1:0] mode;
    logic [7:0] bpm_out;
    logic       note_en, busy, done;

    logic [7:0] mem [32];
    obs_t       exp_q [$];
    logic [3:0] m_note;
    logic [1:0] m_mode;
    logic [7:0] m_bpm;
    logic [4:0] m_addr;
    int         checks = 0;
    int         errors = 0;

    note_sequencer #(.CLK_HZ(CLK_HZ), .ADDR_W(5)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop), .LOOP(loop_en), .BPM(bpm),
        .PAT_ADDR(pat_addr), .PAT_DATA(pat_data), .NOTE(note), .MODE(mode),
        .BPM_OUT(bpm_out), .NOTE_EN(note_en), .BUSY(busy), .DONE(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pat_data <= mem[pat_addr];

    function automatic obs_t mk(input logic b, input logic d, input logic en, input logic [3:0] n,
                                input logic [1:0] md, input logic [4:0] a, input logic [7:0] bp);
        return {b, d, en, n, md, a, bp};
    endfunction

    task automatic chk(input string tag, input int idx, input obs_t exp, output bit ok);
        obs_t o;
        o = {busy, done, note_en, note, mode, pat_addr, bpm_out};
        checks++;
        ok = (o === exp);
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, exp);
        end
    endtask

    // Expected per-cycle timeline: each entry costs FETCH+LOAD, then the PLAY cycles
    // needed for cumulative ticks, where ticks after C play cycles = floor(C*2*BPM/LIMIT).
    task automatic build(input bit lp, input int max_len);
        longint tk = 0, cy = 0, c;
        int     a = 0;
        int     t;
        bit     fin = 0;
        logic [7:0] e;
        exp_q.delete();
        while (!fin && exp_q.size() < max_len) begin
            repeat (2) exp_q.push_back(mk(1, 0, 0, m_note, m_mode, 5'(a), m_bpm));
            e = mem[a];
            if (e[7]) begin
                if (lp && a != 0) a = 0;
                else fin = 1;
            end else begin
                m_note = e[3:0];
                m_mode = e[6:5];
                t  = 8 >> e[6:5];
                tk = tk + t;
                c  = (tk * LIMIT + 2 * longint'(m_bpm) - 1) / (2 * longint'(m_bpm));
                repeat (int'(c - cy)) exp_q.push_back(mk(1, 0, !e[4], m_note, m_mode, 5'(a), m_bpm));
                cy = c;
                if (a == 31) begin
                    if (lp) a = 0;
                    else fin = 1;
                end else begin
                    a++;
                end
            end
        end
        if (fin) begin
            exp_q.push_back(mk(0, 1, 0, m_note, m_mode, 5'(a), m_bpm));
            exp_q.push_back(mk(0, 0, 0, m_note, m_mode, 5'(a), m_bpm));
        end
    endtask

    task automatic run(input logic [7:0] b, input int start_at, input int stop_at, input string tag);
        int   n;
        bit   ok = 1;
        obs_t last;
        @(negedge clk);
        bpm   = b;
        start = 1'b1;
        n = exp_q.size();
        if (stop_at >= 0 && stop_at < n) n = stop_at + 1;
        last = exp_q[n-1];
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            chk(tag, i, exp_q[i], ok);
            if (!ok) break;
            if (i == start_at) begin
                start = 1'b1;
                bpm   = b + 8'd7;
            end
            if (i == stop_at) stop = 1'b1;
        end
        if (!ok) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b1;
            @(negedge clk);
            stop  = 1'b0;
        end else if (stop_at >= 0) begin
            last = {3'b000, last[18:0]};
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                stop = 1'b0;
                chk({tag, "_stopped"}, k, last, ok);
            end
        end
        m_note = last[18:15];
        m_mode = last[14:13];
        m_addr = last[12:8];
    endtask

    task automatic set_melody();
        for (int i = 0; i < 32; i++) mem[i] = 8'h80;
        mem[0] = 8'h27;
        mem[1] = 8'h62;
        mem[2] = 8'h80;
    endtask

    initial begin
        bit ok;
        int len, sa;
        logic [7:0] rb;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; bpm = 8'd0;
        m_note = 0; m_mode = 0; m_bpm = 0; m_addr = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h80;
        repeat (3) @(negedge clk);
        chk("reset", 0, mk(0, 0, 0, 0, 0, 0, 0), ok);
        rst = 1'b0;

        set_melody();
        m_bpm = 8'd60;
        build(0, 100000);
        run(8'd60, -1, -1, "melody");

        loop_en = 1'b1;
        build(1, 400);
        run(8'd60, -1, exp_q.size() - 1, "loop");
        loop_en = 1'b0;

        mem[0] = 8'h53;
        mem[1] = 8'h80;
        build(0, 100000);
        run(8'd60, -1, -1, "rest");

        @(negedge clk);
        bpm = 8'd90; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start_stop", 0, mk(0, 0, 0, m_note, m_mode, m_addr, m_bpm), ok);
        bpm = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bpm_zero", 0, mk(0, 0, 0, m_note, m_mode, m_addr, m_bpm), ok);
        @(negedge clk);
        chk("bpm_zero_hold", 1, mk(0, 0, 0, m_note, m_mode, m_addr, m_bpm), ok);

        set_melody();
        build(0, 100000);
        run(8'd60, 30, -1, "start_busy");

        for (int i = 0; i < 32; i++) mem[i] = 8'h63;
        build(0, 100000);
        run(8'd60, -1, -1, "fill32");

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'h80;
            len = $urandom_range(6, 1);
            for (int i = 0; i < len; i++) begin
                rb = 8'($urandom);
                mem[i] = {1'b0, rb[6:0]};
            end
            rb = 8'($urandom_range(255, 40));
            loop_en = (k >= 4);
            m_bpm = rb;
            build(loop_en, loop_en ? 600 : 100000);
            sa = exp_q[exp_q.size() - 1][21] ? exp_q.size() - 1 : -1;
            run(rb, -1, sa, "random");
        end
        loop_en = 1'b0;

        set_melody();
        m_bpm = 8'd60;
        @(negedge clk);
        bpm = 8'd60; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1; start = 1'b1; stop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reset_mid", k, mk(0, 0, 0, 0, 0, 0, 0), ok);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        m_note = 0; m_mode = 0; m_addr = 0;
        m_bpm = 8'd60;
        build(0, 100000);
        run(8'd60, -1, -1, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
